// File: rtl/uart_frame_assembler.sv
// Receive-side framer: assembles 7-bit-payload UART bytes into a 32-bit remote state word.
// Define UART_FRAME_CHECKSUM_EN to add a sixth XOR checksum byte to every frame.
module uart_frame_assembler #(
    parameter int BYTE_TIMEOUT = 4,
    parameter int LINK_TIMEOUT = 30,
    parameter int ERR_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             timing_tick,
    input  logic [7:0]       rx_data,
    input  logic             rx_done_tick,
    output logic [31:0]      rx_buf,
    output logic             frame_valid,
    output logic             link_up,
    output logic [ERR_W-1:0] err_count
);

    // Input handshake: rx_data is valid only in the cycle rx_done_tick is high; there is
    // no ready/backpressure, so every strobed byte is consumed in the cycle it arrives.

`ifdef UART_FRAME_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd5;
`else
    localparam logic [2:0] LAST_IDX = 3'd4;
`endif
    localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);
    localparam int LT_W = $clog2(LINK_TIMEOUT + 1);
    localparam logic [BT_W-1:0] BT_LAST = BT_W'(BYTE_TIMEOUT - 1);
    localparam logic [LT_W-1:0] LT_MAX  = LT_W'(LINK_TIMEOUT);

    typedef enum logic [1:0] {HUNT, COLLECT, COMMIT} state_t;

    state_t          state;
    logic [2:0]      idx;
    logic [31:0]     shadow;
    logic [31:0]     shadow_next;
    logic [BT_W-1:0] byte_timer;
    logic [LT_W-1:0] link_timer;
    logic            csum_ok;
    logic            commit_now;

`ifdef UART_FRAME_CHECKSUM_EN
    logic [6:0] csum;
    assign csum_ok = (rx_data[6:0] == csum);
`else
    assign csum_ok = 1'b1;
`endif

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Shadow word with the current byte merged in at its slot.
    always_comb begin
        shadow_next = shadow;
        case (idx)
            3'd1:    shadow_next[27:21] = rx_data[6:0];
            3'd2:    shadow_next[20:14] = rx_data[6:0];
            3'd3:    shadow_next[13:7]  = rx_data[6:0];
            3'd4:    shadow_next[6:0]   = rx_data[6:0];
            default: shadow_next = shadow;
        endcase
    end

    assign commit_now = (state == COLLECT) && rx_done_tick && !rx_data[7] &&
                        (idx == LAST_IDX) && csum_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            idx         <= 3'd0;
            shadow      <= 32'd0;
            rx_buf      <= 32'd0;
            frame_valid <= 1'b0;
            link_up     <= 1'b0;
            err_count   <= '0;
            byte_timer  <= '0;
            link_timer  <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
            csum        <= 7'd0;
`endif
        end else begin
            frame_valid <= 1'b0;

            // A commit beats a coincident tick: timer cleared, link stays up.
            if (commit_now) begin
                link_timer <= '0;
                link_up    <= 1'b1;
            end else if (timing_tick && link_timer != LT_MAX) begin
                link_timer <= link_timer + 1'b1;
                if (link_timer == LT_MAX - 1'b1)
                    link_up <= 1'b0;
            end

            case (state)
                // COMMIT lasts one cycle and treats a byte exactly like HUNT does.
                HUNT, COMMIT: begin
                    state <= HUNT;
                    if (rx_done_tick) begin
                        if (rx_data[7]) begin
                            shadow     <= {rx_data[3:0], 28'd0};
                            idx        <= 3'd1;
                            byte_timer <= '0;
                            state      <= COLLECT;
`ifdef UART_FRAME_CHECKSUM_EN
                            csum       <= rx_data[6:0];
`endif
                        end else begin
                            err_count <= sat_inc(err_count);
                        end
                    end
                end
                COLLECT: begin
                    if (rx_done_tick) begin
                        byte_timer <= '0;
                        if (rx_data[7]) begin
                            err_count <= sat_inc(err_count);
                            shadow    <= {rx_data[3:0], 28'd0};
                            idx       <= 3'd1;
`ifdef UART_FRAME_CHECKSUM_EN
                            csum      <= rx_data[6:0];
`endif
                        end else if (idx == LAST_IDX) begin
                            if (csum_ok) begin
                                rx_buf      <= shadow_next;
                                frame_valid <= 1'b1;
                                state       <= COMMIT;
                            end else begin
                                err_count <= sat_inc(err_count);
                                state     <= HUNT;
                            end
                        end else begin
                            shadow <= shadow_next;
                            idx    <= idx + 3'd1;
`ifdef UART_FRAME_CHECKSUM_EN
                            csum   <= csum ^ rx_data[6:0];
`endif
                        end
                    end else if (timing_tick) begin
                        if (byte_timer == BT_LAST) begin
                            byte_timer <= '0;
                            err_count  <= sat_inc(err_count);
                            state      <= HUNT;
                        end else begin
                            byte_timer <= byte_timer + 1'b1;
                        end
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule
